// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller for the EX-stage ALU operand muxes.
// Optional HAZ_STALL_CNT_EN adds a saturating 16-bit stall_count output.
module fwd_hazard_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_dest,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic [4:0] dest;
  } shadow_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  shadow_t ex_q, mem_q, wb_q;
  shadow_t id_e;
  logic    id_accept;
  logic    lu_rs, lu_rt;

  function automatic logic live(input shadow_t e, input logic [4:0] r);
    return e.valid && e.regwrite && (e.dest == r) && (e.dest != 5'd0);
  endfunction

  // ex_q is the newest producer and so takes priority over mem_q
  function automatic logic [1:0] pick(input logic uses, input logic [4:0] r,
                                      input shadow_t ex, input shadow_t mem);
    if (!uses)             return SEL_RF;
    else if (live(ex, r))  return SEL_MEM;
    else if (live(mem, r)) return SEL_WB;
    else                   return SEL_RF;
  endfunction

  always_comb begin
    lu_rs     = id_uses_rs && live(ex_q, id_rs);
    lu_rt     = id_uses_rt && live(ex_q, id_rt);
    stall     = id_valid && !flush && ex_q.memread && (lu_rs || lu_rt);
    id_accept = id_valid && !flush && !stall;
    id_e      = '{valid: 1'b1, regwrite: id_regwrite, memread: id_memread, dest: id_dest};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else begin
      ex_q      <= id_accept ? id_e : '0;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      fwd_a_sel <= id_accept ? pick(id_uses_rs, id_rs, ex_q, mem_q) : SEL_RF;
      fwd_b_sel <= id_accept ? pick(id_uses_rt, id_rt, ex_q, mem_q) : SEL_RF;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= 16'd0;
    else if (stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding selects, load-use stall, $0, flush, reset.
// Counter checks are compiled in only when HAZ_STALL_CNT_EN is defined.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_regwrite, id_memread, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;
`ifdef HAZ_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_dest     (id_dest),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall)
`ifdef HAZ_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dest,
                       input logic rw, input logic mr);
    id_valid    = v;
    flush       = fl;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rs  = urs;
    id_uses_rt  = urt;
    id_dest     = dest;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  // Present one ID instruction, check stall mid-cycle, then the selects it gets in EX.
  task automatic op(input logic v, input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                    input logic urs, input logic urt, input logic [4:0] dest,
                    input logic rw, input logic mr,
                    input logic es, input logic [1:0] ea, input logic [1:0] eb,
                    input string tag);
    drive(v, fl, rs, rt, urs, urt, dest, rw, mr);
    @(negedge clk);
    check({tag, "_stall"}, 16'(stall), 16'(es));
    @(posedge clk);
    #1;
    check({tag, "_a"}, 16'(fwd_a_sel), 16'(ea));
    check({tag, "_b"}, 16'(fwd_b_sel), 16'(eb));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_a", 16'(fwd_a_sel), 16'd0);
    check("rst_b", 16'(fwd_b_sel), 16'd0);
    check("rst_stall", 16'(stall), 16'd0);
`ifdef HAZ_STALL_CNT_EN
    check("rst_cnt", stall_count, 16'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // EX forward
    op(1, 0, 1, 2, 1, 1,  3, 1, 0, 0, 2'b00, 2'b00, "add3");
    op(1, 0, 3, 4, 1, 1,  6, 1, 0, 0, 2'b01, 2'b00, "ex_fwd");
    // MEM forward across a nop
    op(1, 0, 1, 2, 1, 1,  5, 1, 0, 0, 2'b00, 2'b00, "add5");
    op(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, "nop");
    op(1, 0, 7, 5, 1, 1,  9, 1, 0, 0, 2'b00, 2'b10, "mem_fwd");
    // newest producer wins
    op(1, 0, 1, 2, 1, 1,  5, 1, 0, 0, 2'b00, 2'b00, "add5a");
    op(1, 0, 1, 2, 1, 1,  5, 1, 0, 0, 2'b00, 2'b00, "add5b");
    op(1, 0, 5, 5, 1, 1, 10, 1, 0, 0, 2'b01, 2'b01, "prio");
    // load-use: one stall cycle, then forward from MEM/WB
    op(1, 0, 1, 0, 1, 0,  8, 1, 1, 0, 2'b00, 2'b00, "lw8");
    op(1, 0, 8, 8, 1, 1, 11, 1, 0, 1, 2'b00, 2'b00, "lu_stall");
`ifdef HAZ_STALL_CNT_EN
    check("lu_cnt1", stall_count, 16'd1);
`endif
    op(1, 0, 8, 8, 1, 1, 11, 1, 0, 0, 2'b10, 2'b10, "lu_fwd");
`ifdef HAZ_STALL_CNT_EN
    check("lu_cnt2", stall_count, 16'd1);
`endif
    // register $0 never forwards or stalls
    op(1, 0, 1, 2, 1, 1,  0, 1, 0, 0, 2'b00, 2'b00, "wr0");
    op(1, 0, 0, 0, 1, 1, 12, 1, 0, 0, 2'b00, 2'b00, "use0");
    op(1, 0, 1, 0, 1, 0,  0, 1, 1, 0, 2'b00, 2'b00, "lw0");
    op(1, 0, 0, 0, 1, 1, 13, 1, 0, 0, 2'b00, 2'b00, "lu0");
    // flush beats stall and leaves a bubble in EX
    op(1, 0, 1, 0, 1, 0,  8, 1, 1, 0, 2'b00, 2'b00, "lw8b");
    op(1, 1, 8, 8, 1, 1, 14, 1, 0, 0, 2'b00, 2'b00, "flush");
    op(1, 0, 8, 2, 1, 1, 30, 1, 0, 0, 2'b10, 2'b00, "post_flush");
`ifdef HAZ_STALL_CNT_EN
    check("flush_cnt", stall_count, 16'd1);
`endif
    // independent instructions
    for (int i = 0; i < 10; i++)
      op(1, 0, 5'(i + 1), 5'(i + 11), 1, 1, 5'(i + 21), 1, 0, 0, 2'b00, 2'b00, "indep");

    // async reset with a load in EX and its consumer stalled in ID
    op(1, 0, 1, 2, 1, 1,  3, 1, 0, 0, 2'b00, 2'b00, "r_add3");
    op(1, 0, 3, 0, 1, 0,  8, 1, 1, 0, 2'b01, 2'b00, "r_lw8");
    drive(1, 0, 8, 3, 1, 1, 15, 1, 0);
    @(negedge clk);
    check("r_pre_stall", 16'(stall), 16'd1);
    #1 rst = 1'b1;
    #1;
    check("r_stall", 16'(stall), 16'd0);
    check("r_a", 16'(fwd_a_sel), 16'd0);
    check("r_b", 16'(fwd_b_sel), 16'd0);
`ifdef HAZ_STALL_CNT_EN
    check("r_cnt", stall_count, 16'd0);
`endif
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("r_post_a", 16'(fwd_a_sel), 16'd0);
    check("r_post_b", 16'(fwd_b_sel), 16'd0);
    op(1, 0, 8, 3, 1, 1, 15, 1, 0, 0, 2'b00, 2'b00, "r_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
